pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 146 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock watchdog on the board clock.
// Optional loss/retry counters are built with PLL_SUP_LOSS_CNT_EN.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 250000,
    parameter int STABLE_CYCLES  = 25000,
    parameter int CNT_W          = 8
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             pll_ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] retry_count
);

    localparam int M1   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                          PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXC = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
    localparam int TW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    localparam logic [TW-1:0] RST_LD = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LD  = TW'(LOCK_TIMEOUT);
    localparam logic [TW-1:0] STB_LD = TW'(STABLE_CYCLES - 1);

    localparam logic [2:0] S_PRST = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_LOST = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic [2:0]             state, state_d;
    logic [TW-1:0]          cnt, cnt_d;
    logic                   cnt_zero;
    logic                   loss_inc;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign lk       = sync_q[SYNC_STAGES-1];
    assign cnt_zero = (cnt == '0);
    assign loss_inc = (state == S_RUN) && !lk;

    always_comb begin
        state_d = state;
        cnt_d   = cnt_zero ? cnt : cnt - 1'b1;
        case (state)
            S_PRST: begin
                if (cnt_zero) begin
                    state_d = S_WAIT;
                    cnt_d   = TO_LD;
                end
            end
            S_WAIT: begin
                // a lock seen on the timeout cycle takes priority
                if (lk) begin
                    state_d = S_STAB;
                    cnt_d   = STB_LD;
                end else if (cnt_zero) begin
                    state_d = S_PRST;
                    cnt_d   = RST_LD;
                end
            end
            S_STAB: begin
                if (!lk) begin
                    state_d = S_WAIT;
                    cnt_d   = TO_LD;
                end else if (cnt_zero) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt;
                if (!lk) begin
                    state_d = S_LOST;
                end
            end
            S_LOST: begin
                state_d = S_PRST;
                cnt_d   = RST_LD;
            end
            default: begin
                state_d = S_PRST;
                cnt_d   = RST_LD;
            end
        endcase
    end

    // outputs are registered from the next state so they never glitch
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PRST;
            cnt       <= RST_LD;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pll_rst   <= (state_d == S_PRST);
            sys_rst_n <= (state_d == S_RUN);
            pll_ready <= (state_d == S_RUN);
            lock_lost <= lock_lost | loss_inc;
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    logic             retry_inc;
    logic [CNT_W-1:0] loss_q, retry_q;

    assign retry_inc = (state == S_WAIT) && !lk && cnt_zero;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            loss_q  <= '0;
            retry_q <= '0;
        end else begin
            if (loss_inc && (loss_q != '1)) begin
                loss_q <= loss_q + 1'b1;
            end
            if (retry_inc && (retry_q != '1)) begin
                retry_q <= retry_q + 1'b1;
            end
        end
    end

    assign loss_count  = loss_q;
    assign retry_count = retry_q;
`else
    assign loss_count  = '0;
    assign retry_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Counter expectations follow PLL_SUP_LOSS_CNT_EN.
module tb_pll_lock_supervisor;

    localparam int CW = 4;
`ifdef PLL_SUP_LOSS_CNT_EN
    localparam int EN = 1;
`else
    localparam int EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          locked = 1'b0;
    logic          pll_rst, sys_rst_n, pll_ready, lock_lost;
    logic [CW-1:0] loss_count, retry_count;

    int total = 0;
    int pass  = 0;
    logic bad;

    pll_lock_supervisor #(
        .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
        .STABLE_CYCLES(10), .CNT_W(CW)
    ) dut (
        .clkin(clk), .rst_n(rst_n), .locked(locked),
        .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
        .pll_ready(pll_ready), .lock_lost(lock_lost),
        .loss_count(loss_count), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
        chk({tag, "_pll_ready"}, 32'(pll_ready), 0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 0);
        chk({tag, "_loss"}, 32'(loss_count), 0);
        chk({tag, "_retry"}, 32'(retry_count), 0);
    endtask

    initial begin
        // power-on reset with lock already present
        locked = 1'b1;
        tick(2);
        chk_rst_vals("por");
        rst_n = 1'b1;
        tick(3);
        chk("prst_hold", 32'(pll_rst), 1);
        tick(1);
        chk("prst_end", 32'(pll_rst), 0);
        tick(10);
        chk("pre_run_sys", 32'(sys_rst_n), 0);
        tick(1);
        chk("run_sys", 32'(sys_rst_n), 1);
        chk("run_ready", 32'(pll_ready), 1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!sys_rst_n || !pll_ready) bad = 1'b1;
        end
        chk("run_stays", 32'(bad), 0);
        chk("run_no_loss", 32'(lock_lost), 0);

        // lock drop in RUN, then relock
        locked = 1'b0;
        tick(2);
        chk("drop_sys_hold", 32'(sys_rst_n), 1);
        tick(1);
        chk("drop_sys", 32'(sys_rst_n), 0);
        chk("drop_ready", 32'(pll_ready), 0);
        chk("drop_flag", 32'(lock_lost), 1);
        chk("drop_loss", 32'(loss_count), 32'(EN));
        locked = 1'b1;
        tick(1);
        chk("drop_prst", 32'(pll_rst), 1);
        tick(14);
        chk("relock_pre", 32'(sys_rst_n), 0);
        tick(1);
        chk("relock_run", 32'(sys_rst_n), 1);
        chk("relock_flag", 32'(lock_lost), 1);
        chk("relock_loss", 32'(loss_count), 32'(EN));

        // async reset mid-RUN
        #2 rst_n = 1'b0;
        #1 chk_rst_vals("arst_run");

        // glitch during STABILIZE
        tick(1);
        rst_n = 1'b1;
        tick(7);
        locked = 1'b0;
        tick(3);
        chk("glitch_sys", 32'(sys_rst_n), 0);
        chk("glitch_prst", 32'(pll_rst), 0);
        locked = 1'b1;
        tick(12);
        chk("glitch_pre", 32'(sys_rst_n), 0);
        tick(1);
        chk("glitch_run", 32'(sys_rst_n), 1);

        // async reset mid-STABILIZE
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        chk("stab_sys", 32'(sys_rst_n), 0);
        #2 rst_n = 1'b0;
        #1 chk_rst_vals("arst_stab");

        // no lock ever: periodic retries, saturating count
        locked = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick(24);
            chk($sformatf("to_wait%0d", k), 32'(pll_rst), 0);
            tick(1);
            chk($sformatf("to_prst%0d", k), 32'(pll_rst), 1);
            chk($sformatf("retry%0d", k), 32'(retry_count),
                32'(EN * ((k > 15) ? 15 : k)));
        end
        chk("retry_sys", 32'(sys_rst_n), 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
